// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, instruction layout and sequencer types
package alu_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_NREGS  = 4;

    localparam int INSTR_W = 10;
    localparam int LD_POS  = 9;
    localparam int OP_LSB  = 6;
    localparam int OP_W    = 3;
    localparam int RD_LSB  = 4;
    localparam int RS1_LSB = 2;
    localparam int RS2_LSB = 0;
    localparam int REG_W   = 2;
    localparam int IMM_W   = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND  = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR   = 3'b011;
    localparam logic [OP_W-1:0] ALU_XOR  = 3'b100;
    localparam logic [OP_W-1:0] ALU_SHL1 = 3'b101;
    localparam logic [OP_W-1:0] ALU_SHR1 = 3'b110;
    localparam logic [OP_W-1:0] ALU_NOT  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Field order mirrors the bit positions above; imm overlays {rs1, rs2}.
    typedef struct packed {
        logic             ld;
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } instr_t;

    function automatic logic op_sets_carry(input logic [OP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction, ALU, writeback and debug signals of the issue controller
interface alu_issue_ctrl_if #(
    parameter int DATA_W = alu_pkg::DEF_DATA_W
);
    logic                      in_valid;
    logic                      in_ready;
    logic [alu_pkg::INSTR_W-1:0] in_instr;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [alu_pkg::OP_W-1:0]  alu_sel;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_carry;
    logic                      wb_valid;
    logic [alu_pkg::REG_W-1:0] wb_addr;
    logic                      c_flag;
    logic                      z_flag;
    logic [alu_pkg::REG_W-1:0] dbg_addr;
    logic [DATA_W-1:0]         dbg_data;

    modport slave (
        input  in_valid, in_instr, alu_result, alu_carry, dbg_addr,
        output in_ready, alu_a, alu_b, alu_sel, wb_valid, wb_addr, c_flag, z_flag, dbg_data
    );

    modport master (
        output in_valid, in_instr, alu_result, alu_carry, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_sel, wb_valid, wb_addr, c_flag, z_flag, dbg_data
    );
endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with two operand reads, a debug read and one write port
module alu_regfile #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rd0_addr,
    output logic [DATA_W-1:0]        rd0_data,
    input  logic [$clog2(NREGS)-1:0] rd1_addr,
    output logic [DATA_W-1:0]        rd1_data,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data
);

    logic [DATA_W-1:0] rf [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    assign rd0_data = rf[rd0_addr];
    assign rd1_data = rf[rd1_addr];
    assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - two-cycle issue sequencer feeding a combinational 4-bit ALU
module alu_issue_ctrl #(
    parameter int DATA_W = alu_pkg::DEF_DATA_W,
    parameter int NREGS  = alu_pkg::DEF_NREGS
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_ctrl_if.slave bus
);
    import alu_pkg::*;

    state_t            state;
    state_t            state_nxt;
    instr_t            ir;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd0_addr (ir.rs1),
        .rd0_data (rs1_data),
        .rd1_addr (ir.rs2),
        .rd1_data (rs2_data),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (ir.rd),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.in_valid) begin
                ir <= instr_t'(bus.in_instr);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operands are presented for loads too; the result is simply not used then.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_sel  = '0;
        wr_en        = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            EXEC: begin
                bus.alu_a   = rs1_data;
                bus.alu_b   = rs2_data;
                bus.alu_sel = ir.op;
                wr_en       = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign wr_data = ir.ld ? DATA_W'({ir.rs1, ir.rs2}) : bus.alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_valid <= 1'b0;
            bus.wb_addr  <= '0;
            bus.c_flag   <= 1'b0;
            bus.z_flag   <= 1'b0;
        end else begin
            bus.wb_valid <= wr_en;
            if (wr_en) begin
                bus.wb_addr <= ir.rd;
                bus.z_flag  <= (wr_data == '0);
                if (!ir.ld && op_sets_carry(ir.op)) begin
                    bus.c_flag <= bus.alu_carry;
                end
            end
        end
    end

endmodule
